// File: rtl/pmod_report_pkg.sv
// Shared types and constants for the PMOD input reporter.
//   tx_state_t : UART transmitter states
//   FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS  : payload bits per frame
//   cnt_width  : counter width for a modulo-n counter, never zero
package pmod_report_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // A counter that only has to reach n-1 needs $clog2(n) bits, which is
    // zero for n == 1, so clamp it to one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for one byte per request.
//   clk, rst : clock, synchronous active-high reset
//   start    : request a frame; accepted only while idle
//   data     : byte to send, captured when start is accepted
//   tx       : serial output, idle high, driven from a flop
//   busy     : high during start, data and stop bits
module uart_tx_byte
    import pmod_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy
);

    localparam int                BAUD_W   = cnt_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W    = cnt_width(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_last;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        baud_last = (baud_q == BAUD_MAX);

        // tx_d is set one edge ahead of each bit so the line changes exactly
        // on the bit boundary while staying a registered output.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = data;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_MAX) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/pmod_input_reporter.sv
// Synchronises and debounces 8 PMOD input pins and reports every accepted
// change to the ESP32 as one 8N1 UART frame.
//   clk, rst     : clock, synchronous active-high reset
//   pmod_in      : asynchronous PMOD pins
//   gpio_tx_out  : UART line to the ESP32, idle high
//   pmod_state   : current debounced pin value
//   change_pulse : one-cycle strobe when pmod_state updates
//   busy         : high while a frame is on gpio_tx_out
module pmod_input_reporter
    import pmod_report_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 234,
    parameter int DEBOUNCE_CYCLES = 27000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pmod_in,
    output logic       gpio_tx_out,
    output logic [7:0] pmod_state,
    output logic       change_pulse,
    output logic       busy
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  cand_q, cand_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [7:0]                  state_q, state_d;
    logic                        pulse_q, pulse_d;
    logic [7:0]                  last_sent_q, last_sent_d;
    logic [7:0]                  sync_v;
    logic                        tx_busy;
    logic                        send;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pmod_in};
        sync_v = sync_q[SYNC_STAGES-1];

        cand_d  = cand_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        pulse_d = 1'b0;

        // The whole vector debounces as one: any bit moving restarts the
        // hold time. Once saturated the counter parks at CNT_MAX, so a
        // candidate equal to the current state is simply held there.
        if (sync_v != cand_q) begin
            cand_d = sync_v;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            if (cand_q != state_q) begin
                state_d = cand_q;
                pulse_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Only idle looks at pending, so mid-frame changes coalesce into one
        // frame carrying the latest value, and a revert to what was last sent
        // produces nothing.
        send        = (state_q != last_sent_q) && !tx_busy;
        last_sent_d = send ? state_q : last_sent_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            state_q     <= '0;
            pulse_q     <= 1'b0;
            last_sent_q <= '0;
        end else begin
            sync_q      <= sync_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            last_sent_q <= last_sent_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(send),
        .data (state_q),
        .tx   (gpio_tx_out),
        .busy (tx_busy)
    );

    assign pmod_state   = state_q;
    assign change_pulse = pulse_q;
    assign busy         = tx_busy;

endmodule

// File: tb/tb_pmod_input_reporter.sv
module tb_pmod_input_reporter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pmod_in = 8'h00;
    logic       gpio_tx_out;
    logic [7:0] pmod_state;
    logic       change_pulse;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int pulse_cnt = 0;

    pmod_input_reporter #(
        .CLKS_PER_BIT(CPB),
        .DEBOUNCE_CYCLES(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pmod_in     (pmod_in),
        .gpio_tx_out (gpio_tx_out),
        .pmod_state  (pmod_state),
        .change_pulse(change_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (change_pulse === 1'b1) pulse_cnt++;

    task automatic step();
        @(negedge clk);
    endtask

    // Expected line, one sample per clock: start, LSB..MSB, stop, CPB each.
    function automatic logic [39:0] exp_trace(input logic [7:0] v);
        logic [9:0]  f;
        logic [39:0] r;
        f = {1'b1, v, 1'b0};
        for (int k = 0; k < 40; k++) r[k] = f[k / CPB];
        return r;
    endfunction

    // Waits (bounded) for the line to fall, then records 40 cycles of tx/busy
    // and the cycle right after. Optionally changes pmod_in at cycle inj_k.
    task automatic capture_frame(input int inj_k, input logic [7:0] inj_v,
                                 output logic [39:0] tx_tr, output logic [39:0] busy_tr,
                                 output logic tx_after, output logic busy_after,
                                 output int waited, output bit timeout);
        waited  = 0;
        timeout = 1'b0;
        tx_tr   = '0;
        busy_tr = '0;
        while (gpio_tx_out !== 1'b0 && waited < 200) begin
            step();
            waited++;
        end
        if (gpio_tx_out !== 1'b0) begin
            timeout    = 1'b1;
            tx_after   = gpio_tx_out;
            busy_after = busy;
        end else begin
            for (int k = 0; k < 40; k++) begin
                tx_tr[k]   = gpio_tx_out;
                busy_tr[k] = busy;
                if (k == inj_k) pmod_in = inj_v;
                step();
            end
            tx_after   = gpio_tx_out;
            busy_after = busy;
        end
    endtask

    task automatic test_reset();
        int bad;
        int p0;
        rst = 1'b1;
        pmod_in = 8'h00;
        step();
        step();
        n_total++;
        if ({gpio_tx_out, busy, pmod_state, change_pulse} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset_outputs: tx=%b busy=%b state=%h pulse=%b, want 1 0 00 0",
                     gpio_tx_out, busy, pmod_state, change_pulse);
        end else n_pass++;
        rst = 1'b0;
        p0 = pulse_cnt;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (gpio_tx_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL reset_idle_hold: %0d bad cycles, want 0", bad);
        else n_pass++;
        n_total++;
        if (pulse_cnt != p0) $display("FAIL reset_no_pulse: pulses=%0d, want 0", pulse_cnt - p0);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [39:0] ttr, btr;
        logic ta, ba;
        int w;
        bit to;
        int p0;
        p0 = pulse_cnt;
        pmod_in = 8'hA5;
        for (int i = 0; i < 10; i++) step();
        n_total++;
        if (pmod_state !== 8'h00) $display("FAIL a5_early: state=%h after 10 cycles, want 00", pmod_state);
        else n_pass++;
        step();
        n_total++;
        if (pmod_state !== 8'hA5 || change_pulse !== 1'b1 || gpio_tx_out !== 1'b1)
            $display("FAIL a5_latency: state=%h pulse=%b tx=%b after 11 cycles, want a5 1 1",
                     pmod_state, change_pulse, gpio_tx_out);
        else n_pass++;
        step();
        n_total++;
        if (change_pulse !== 1'b0) $display("FAIL a5_pulse_width: pulse=%b, want 0", change_pulse);
        else n_pass++;
        capture_frame(-1, 8'h00, ttr, btr, ta, ba, w, to);
        n_total++;
        if (to || w != 0) $display("FAIL a5_start_edge: waited=%0d timeout=%0d, want 0 0", w, to);
        else n_pass++;
        n_total++;
        if (ttr !== exp_trace(8'hA5)) $display("FAIL a5_frame: tx=%h, want %h", ttr, exp_trace(8'hA5));
        else n_pass++;
        n_total++;
        if (btr !== {40{1'b1}} || ba !== 1'b0 || ta !== 1'b1)
            $display("FAIL a5_busy: busy=%h after busy=%b tx=%b, want ffffffffff 0 1", btr, ba, ta);
        else n_pass++;
        n_total++;
        if (pulse_cnt != p0 + 1) $display("FAIL a5_pulse_count: %0d, want 1", pulse_cnt - p0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int bad;
        int p0;
        rst = 1'b1;
        pmod_in = 8'h00;
        step();
        step();
        rst = 1'b0;
        p0 = pulse_cnt;
        pmod_in = 8'h01;
        for (int i = 0; i < 5; i++) step();
        pmod_in = 8'h00;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy !== 1'b0 || gpio_tx_out !== 1'b1) bad++;
        end
        n_total++;
        if (pmod_state !== 8'h00) $display("FAIL glitch_state: state=%h, want 00", pmod_state);
        else n_pass++;
        n_total++;
        if (bad != 0 || pulse_cnt != p0)
            $display("FAIL glitch_no_frame: busy cycles=%0d pulses=%0d, want 0 0", bad, pulse_cnt - p0);
        else n_pass++;
    endtask

    task automatic test_coalesce();
        logic [39:0] ttr, btr;
        logic ta, ba;
        int w;
        bit to;
        int p0;
        int bad;
        p0 = pulse_cnt;
        pmod_in = 8'h3C;
        capture_frame(10, 8'hFF, ttr, btr, ta, ba, w, to);
        n_total++;
        if (to || ttr !== exp_trace(8'h3C))
            $display("FAIL coal_3c_frame: tx=%h timeout=%0d, want %h 0", ttr, to, exp_trace(8'h3C));
        else n_pass++;
        n_total++;
        if (btr !== {40{1'b1}} || ba !== 1'b0 || pmod_state !== 8'hFF)
            $display("FAIL coal_3c_end: busy=%h after=%b state=%h, want ffffffffff 0 ff", btr, ba, pmod_state);
        else n_pass++;
        capture_frame(-1, 8'h00, ttr, btr, ta, ba, w, to);
        n_total++;
        if (to || w != 1) $display("FAIL coal_gap: idle gap=%0d timeout=%0d, want 1 0", w, to);
        else n_pass++;
        n_total++;
        if (ttr !== exp_trace(8'hFF)) $display("FAIL coal_ff_frame: tx=%h, want %h", ttr, exp_trace(8'hFF));
        else n_pass++;
        pmod_in = 8'h81;
        for (int i = 0; i < 4; i++) step();
        pmod_in = 8'hFF;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy !== 1'b0 || gpio_tx_out !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0 || pmod_state !== 8'hFF)
            $display("FAIL coal_81_suppressed: busy cycles=%0d state=%h, want 0 ff", bad, pmod_state);
        else n_pass++;
        n_total++;
        if (pulse_cnt != p0 + 2) $display("FAIL coal_pulses: %0d, want 2", pulse_cnt - p0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] ttr, btr;
        logic ta, ba;
        int w;
        bit to;
        int p0;
        int bad;
        pmod_in = 8'h00;
        w = 0;
        while (gpio_tx_out !== 1'b0 && w < 200) begin
            step();
            w++;
        end
        n_total++;
        if (gpio_tx_out !== 1'b0) $display("FAIL rstmid_frame_start: tx=%b, want 0", gpio_tx_out);
        else n_pass++;
        for (int i = 0; i < 17; i++) step();
        rst = 1'b1;
        pmod_in = 8'hA5;
        step();
        n_total++;
        if ({gpio_tx_out, busy, pmod_state, change_pulse} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL rstmid_outputs: tx=%b busy=%b state=%h pulse=%b, want 1 0 00 0",
                     gpio_tx_out, busy, pmod_state, change_pulse);
        else n_pass++;
        step();
        rst = 1'b0;
        p0 = pulse_cnt;
        capture_frame(-1, 8'h00, ttr, btr, ta, ba, w, to);
        n_total++;
        if (to || ttr !== exp_trace(8'hA5))
            $display("FAIL rstmid_a5_frame: tx=%h timeout=%0d, want %h 0", ttr, to, exp_trace(8'hA5));
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0 || pmod_state !== 8'hA5 || pulse_cnt != p0 + 1)
            $display("FAIL rstmid_single: busy cycles=%0d state=%h pulses=%0d, want 0 a5 1",
                     bad, pmod_state, pulse_cnt - p0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_coalesce();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
